// File: rtl/gcd_sub_unit_if.sv
// Start/done handshake bundle between the relprime loop controller and the
// subtraction GCD engine.
//   master (controller): drives start, a_in, b_in; observes the result side.
//   slave  (gcd unit)  : observes start/operands; drives busy, done, gcd_out,
//                        is_one, iter_count.
interface gcd_sub_unit_if #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CNT_WIDTH = 16
);
  logic                 start;
  logic [WIDTH-1:0]     a_in;
  logic [WIDTH-1:0]     b_in;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     gcd_out;
  logic                 is_one;
  logic [CNT_WIDTH-1:0] iter_count;

  modport master (
    output start, a_in, b_in,
    input  busy, done, gcd_out, is_one, iter_count
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, gcd_out, is_one, iter_count
  );
endinterface

// File: rtl/gcd_sub_unit.sv
// Sequential subtraction-based Euclid GCD engine (one subtractor, one
// comparator) with a start/done handshake.
//   CLK        : rising-edge clock
//   RST_N      : asynchronous active-low reset
//   bus.start  : launch request, sampled only in IDLE
//   bus.a_in   : operand A, bus.b_in : operand B (captured at launch)
//   bus.busy   : high in RUN and DONE
//   bus.done   : one-cycle pulse, result valid
//   bus.gcd_out/is_one/iter_count : result, result==1, subtraction steps;
//                held until the next completion
module gcd_sub_unit #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic           CLK,
  input  logic           RST_N,
  gcd_sub_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     gcd_q, gcd_d;
  logic                 is_one_q, is_one_d;
  logic [CNT_WIDTH-1:0] iter_q, iter_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     result_c;
  logic                 finish_c;
  logic [CNT_WIDTH-1:0] cnt_inc_c;

  // Saturating step counter: sticks at all-ones instead of wrapping.
  assign cnt_inc_c = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    gcd_d    = gcd_q;
    is_one_d = is_one_q;
    iter_d   = iter_q;
    result_c = '0;
    finish_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a_in;
          b_d     = bus.b_in;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Larger operand is always the minuend, so no underflow; equal
        // operands fall through to the b-branch and zero b.
        if (a_q == '0) begin
          result_c = b_q;
          finish_c = 1'b1;
        end else if (b_q == '0) begin
          result_c = a_q;
          finish_c = 1'b1;
        end else if (a_q > b_q) begin
          a_d   = a_q - b_q;
          cnt_d = cnt_inc_c;
        end else begin
          b_d   = b_q - a_q;
          cnt_d = cnt_inc_c;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (finish_c) begin
      state_d  = S_DONE;
      gcd_d    = result_c;
      is_one_d = (result_c == WIDTH'(1));
      iter_d   = cnt_q;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      gcd_q    <= '0;
      is_one_q <= 1'b0;
      iter_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      gcd_q    <= gcd_d;
      is_one_q <= is_one_d;
      iter_q   <= iter_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.gcd_out    = gcd_q;
  assign bus.is_one     = is_one_q;
  assign bus.iter_count = iter_q;

endmodule

// File: tb/tb_gcd_sub_unit.sv
// Scoreboard bench for gcd_sub_unit: launches push expected results, a
// negedge monitor pops and compares on every done pulse.
module tb_gcd_sub_unit;

  localparam int unsigned WIDTH     = 16;
  localparam int unsigned CNT_WIDTH = 16;

  typedef struct {
    logic [WIDTH-1:0]     gcd;
    logic                 one;
    logic [CNT_WIDTH-1:0] iter;
    bit                   chk_iter;
    int                   e0;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_fail;
  bit   prev_done;
  exp_t sb[$];

  gcd_sub_unit_if #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

  gcd_sub_unit #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done) begin
        chk("done_single_cycle", int'(prev_done), 0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("gcd_out", int'(bus.gcd_out), int'(e.gcd));
          chk("is_one", int'(bus.is_one), int'(e.one));
          chk("busy_with_done", int'(bus.busy), 1);
          if (e.chk_iter) begin
            chk("iter_count", int'(bus.iter_count), int'(e.iter));
            chk("done_latency", cyc - e.e0, int'(e.iter) + 1);
          end
        end
      end
      prev_done = bus.done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // Launch one operation; e0 is the cycle count just after the launch edge.
  task automatic launch(input int a, input int b, input int g, input int k,
                        input bit chk_iter, input bit push, input bit hold);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = WIDTH'(a);
    bus.b_in  = WIDTH'(b);
    @(posedge clk);
    #1;
    e.gcd      = WIDTH'(g);
    e.one      = (g == 1);
    e.iter     = CNT_WIDTH'(k);
    e.chk_iter = chk_iter;
    e.e0       = cyc;
    if (push) sb.push_back(e);
    if (!hold) bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 80000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_gcd"}, int'(bus.gcd_out), 0);
    chk({tag, "_is_one"}, int'(bus.is_one), 0);
    chk({tag, "_iter"}, int'(bus.iter_count), 0);
  endtask

  initial begin
    int sweep_g[14];
    exp_t e2;
    n_cmp     = 0;
    n_fail    = 0;
    prev_done = 1'b0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    // gcd(6930, m), 6930 = 2*3^2*5*7*11
    sweep_g = '{0, 0, 2, 3, 2, 5, 6, 7, 2, 9, 10, 11, 6, 1};

    // Reset, then idle with start low.
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_busy", int'(bus.busy), 0);
      chk("idle_done", int'(bus.done), 0);
    end

    // (6930,2): 3464 a-steps to reach (2,2), one equal step -> K=3465.
    launch(6930, 2, 2, 3465, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("busy_after_e0", int'(bus.busy), 1);
    wait_done();
    @(negedge clk);
    chk("busy_after_done", int'(bus.busy), 0);
    chk("done_after_done", int'(bus.done), 0);

    // Relprime sweep over m = 2..13.
    for (int m = 2; m <= 13; m++) begin
      launch(6930, m, sweep_g[m], 0, 1'b0, 1'b1, 1'b0);
      wait_done();
    end

    // Zero operands: K=0, done one edge after launch.
    launch(0, 5, 5, 0, 1'b1, 1'b1, 1'b0);
    wait_done();
    launch(7, 0, 7, 0, 1'b1, 1'b1, 1'b0);
    wait_done();
    launch(0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
    wait_done();

    // start mid-RUN with new operands is ignored.
    launch(6930, 2, 2, 3465, 1'b1, 1'b1, 1'b0);
    repeat (50) @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = 16'd9;
    bus.b_in  = 16'd6;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_mid_run", int'(bus.busy), 1);
    wait_done();

    // start held through DONE: (12,8) -> (4,8) -> (4,4) -> (4,0), K=3.
    // Relaunch lands 2 edges after the first done edge: e0 + K+1 + 2.
    launch(12, 8, 4, 3, 1'b1, 1'b1, 1'b1);
    e2 = sb[0];
    e2.e0 = e2.e0 + 6;
    sb.push_back(e2);
    repeat (9) @(negedge clk);
    bus.start = 1'b0;
    wait_done();

    // Reset mid-operation: no done, outputs cleared immediately.
    launch(6930, 2, 2, 3465, 1'b1, 1'b0, 1'b0);
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midop_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_reset_done", int'(bus.done), 0);
    end

    // Relaunch after reset yields the same result.
    launch(6930, 2, 2, 3465, 1'b1, 1'b1, 1'b0);
    wait_done();
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
